// File: rtl/dll_pkg.sv
// Shared data link layer definitions.
// Holds the DLCMSM link-state encoding, the TX arbiter FSM states and the
// requester index constants used for grant vectors.
package dll_pkg;

    typedef enum logic [1:0] {
        DL_INACTIVE = 2'b00,
        DL_INIT     = 2'b01,
        DL_ACTIVE   = 2'b10
    } dlcmsm_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_RPL  = 2'b01,
        ARB_TLP  = 2'b10
    } arb_state_e;

    localparam int unsigned REQ_RPL  = 0;
    localparam int unsigned REQ_DLLP = 1;
    localparam int unsigned REQ_TLP  = 2;
    localparam int unsigned NUM_REQ  = 3;

endpackage

// File: rtl/dll_tx_arb_prio.sv
// IDLE-state priority and DLCMSM gating selector for the DLL TX arbiter.
// Ports:
//   i_dlcmsm      link state (2'b11 is treated as INACTIVE)
//   i_rpl_valid   replay TLP request
//   i_dllp_valid  DLLP request
//   i_tlp_valid   new TLP request
//   i_fair_force  DLLP burst limit reached: new TLP beats DLLP
//   o_grant       one-hot grant vector indexed by REQ_* (all zero if none)
module dll_tx_arb_prio
    import dll_pkg::*;
(
    input  logic [1:0]         i_dlcmsm,
    input  logic               i_rpl_valid,
    input  logic               i_dllp_valid,
    input  logic               i_tlp_valid,
    input  logic               i_fair_force,
    output logic [NUM_REQ-1:0] o_grant
);

    logic w_active;
    logic w_dllp_ok;

    assign w_active  = (i_dlcmsm == DL_ACTIVE);
    assign w_dllp_ok = w_active || (i_dlcmsm == DL_INIT);

    always_comb begin
        o_grant = '0;
        if (w_active && i_rpl_valid) begin
            o_grant[REQ_RPL] = 1'b1;
        end else if (w_active && i_tlp_valid && i_fair_force) begin
            o_grant[REQ_TLP] = 1'b1;
        end else if (w_dllp_ok && i_dllp_valid) begin
            o_grant[REQ_DLLP] = 1'b1;
        end else if (w_active && i_tlp_valid) begin
            o_grant[REQ_TLP] = 1'b1;
        end
    end

endmodule

// File: rtl/dll_tx_arb.sv
// Data link layer transmit arbiter: shares the PIPE TX datapath between replay
// TLPs, DLLPs and new TLPs. Packets are atomic; one registered beat per cycle.
// Optional feature macro DLL_TX_ARB_FAIR_EN: DLLP-burst fairness counter that
// lets a waiting new TLP through after DLLP_BURST_MAX consecutive DLLPs.
// Ports:
//   sclk, srst_n            clock, async active-low reset
//   dlcmsm_i                link state (00 INACTIVE, 01 INIT, 10 ACTIVE)
//   rpl_valid/last/data_i   replay TLP stream, rpl_ready_o
//   tlp_valid/last/data_i   new TLP stream, tlp_ready_o
//   dllp_valid/data_i       single-beat DLLP, dllp_ready_o
//   pipe_txdata_o/txvalid_o registered PIPE TX beat
//   busy_o                  a multi-beat TLP is mid-stream
module dll_tx_arb
    import dll_pkg::*;
#(
    parameter int unsigned PIPE_DATA_WIDTH = 256,
    parameter int unsigned FAIR_CNT_W      = 4,
    parameter int unsigned DLLP_BURST_MAX  = 8
) (
    input  logic                       sclk,
    input  logic                       srst_n,
    input  logic [1:0]                 dlcmsm_i,
    input  logic                       rpl_valid_i,
    input  logic                       rpl_last_i,
    input  logic [PIPE_DATA_WIDTH-1:0] rpl_data_i,
    output logic                       rpl_ready_o,
    input  logic                       tlp_valid_i,
    input  logic                       tlp_last_i,
    input  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i,
    output logic                       tlp_ready_o,
    input  logic                       dllp_valid_i,
    input  logic [PIPE_DATA_WIDTH-1:0] dllp_data_i,
    output logic                       dllp_ready_o,
    output logic [PIPE_DATA_WIDTH-1:0] pipe_txdata_o,
    output logic                       pipe_txvalid_o,
    output logic                       busy_o
);

    arb_state_e                 r_state;
    arb_state_e                 w_state_next;
    logic [NUM_REQ-1:0]         w_grant;
    logic                       w_fair_force;
    logic                       w_rpl_acc;
    logic                       w_dllp_acc;
    logic                       w_tlp_acc;
    logic [PIPE_DATA_WIDTH-1:0] r_txdata;
    logic                       r_txvalid;

    dll_tx_arb_prio u_prio (
        .i_dlcmsm     (dlcmsm_i),
        .i_rpl_valid  (rpl_valid_i),
        .i_dllp_valid (dllp_valid_i),
        .i_tlp_valid  (tlp_valid_i),
        .i_fair_force (w_fair_force),
        .o_grant      (w_grant)
    );

    // Mid-packet the owning stream keeps ready regardless of link state, so a
    // DLCMSM change never truncates a TLP. Reset forces all ready low at once.
    always_comb begin
        rpl_ready_o  = 1'b0;
        dllp_ready_o = 1'b0;
        tlp_ready_o  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                rpl_ready_o  = w_grant[REQ_RPL];
                dllp_ready_o = w_grant[REQ_DLLP];
                tlp_ready_o  = w_grant[REQ_TLP];
            end
            ARB_RPL: rpl_ready_o = 1'b1;
            ARB_TLP: tlp_ready_o = 1'b1;
            default: ;
        endcase
        if (!srst_n) begin
            rpl_ready_o  = 1'b0;
            dllp_ready_o = 1'b0;
            tlp_ready_o  = 1'b0;
        end
    end

    assign w_rpl_acc  = rpl_valid_i && rpl_ready_o;
    assign w_dllp_acc = dllp_valid_i && dllp_ready_o;
    assign w_tlp_acc  = tlp_valid_i && tlp_ready_o;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE: begin
                // Single-beat packets complete in IDLE without a state change.
                if (w_rpl_acc && !rpl_last_i) begin
                    w_state_next = ARB_RPL;
                end else if (w_tlp_acc && !tlp_last_i) begin
                    w_state_next = ARB_TLP;
                end
            end
            ARB_RPL: if (w_rpl_acc && rpl_last_i) w_state_next = ARB_IDLE;
            ARB_TLP: if (w_tlp_acc && tlp_last_i) w_state_next = ARB_IDLE;
            default: w_state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_state   <= ARB_IDLE;
            r_txvalid <= 1'b0;
            r_txdata  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_txvalid <= w_rpl_acc || w_dllp_acc || w_tlp_acc;
            if (w_rpl_acc) begin
                r_txdata <= rpl_data_i;
            end else if (w_dllp_acc) begin
                r_txdata <= dllp_data_i;
            end else if (w_tlp_acc) begin
                r_txdata <= tlp_data_i;
            end
        end
    end

`ifdef DLL_TX_ARB_FAIR_EN
    localparam logic [FAIR_CNT_W-1:0] BurstMax = FAIR_CNT_W'(DLLP_BURST_MAX);

    logic [FAIR_CNT_W-1:0] r_fair_cnt;

    // Counts DLLPs granted while a new TLP waits; a pending replay neither
    // counts nor clears since replay wins anyway.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_fair_cnt <= '0;
        end else if (!tlp_valid_i || w_tlp_acc) begin
            r_fair_cnt <= '0;
        end else if (w_dllp_acc && !rpl_valid_i && (r_fair_cnt < BurstMax)) begin
            r_fair_cnt <= r_fair_cnt + 1'b1;
        end
    end

    assign w_fair_force = (r_fair_cnt >= BurstMax);
`else
    logic w_unused_fair_params;

    assign w_unused_fair_params = (FAIR_CNT_W == 0) || (DLLP_BURST_MAX == 0);
    assign w_fair_force         = 1'b0;
`endif

    assign pipe_txdata_o  = r_txdata;
    assign pipe_txvalid_o = r_txvalid;
    assign busy_o         = (r_state != ARB_IDLE);

endmodule

// File: doc/dll_tx_arb.md
# dll_tx_arb

Transmit-side arbiter of the data link layer. It shares the single PIPE transmit datapath between three requesters: retry-buffer replay TLPs, DLLPs (ACK/NAK, InitFC, UpdateFC) from the receive side, and new TLPs from the transaction layer. Arbitration is packet-atomic and gated by the DLCMSM state. The output is one registered beat per cycle toward `pipe_txdata_o`/`pipe_txvalid_o`.

## Interface
Parameters:
- `PIPE_DATA_WIDTH`, 256: beat width.
- `FAIR_CNT_W`, 4: width of the DLLP-burst fairness counter.
- `DLLP_BURST_MAX`, 8: consecutive DLLP grants allowed while a new TLP waits.

Ports. Single clock `sclk`; asynchronous active-low reset `srst_n`.
- `sclk` in 1: clock.
- `srst_n` in 1: async reset, active low.
- `dlcmsm_i` in 2: link state. 00 INACTIVE, 01 INIT, 10 ACTIVE, 11 treated as INACTIVE.
- `rpl_valid_i`, `rpl_last_i` in 1 each; `rpl_data_i` in PIPE_DATA_WIDTH; `rpl_ready_o` out 1: replay TLP stream.
- `tlp_valid_i`, `tlp_last_i` in 1 each; `tlp_data_i` in PIPE_DATA_WIDTH; `tlp_ready_o` out 1: new TLP stream.
- `dllp_valid_i` in 1; `dllp_data_i` in PIPE_DATA_WIDTH; `dllp_ready_o` out 1: single-beat DLLP.
- `pipe_txdata_o` out PIPE_DATA_WIDTH; `pipe_txvalid_o` out 1: PIPE TX.
- `busy_o` out 1: a TLP is mid-stream (state ≠ IDLE).

## Operation
- Handshake: a beat transfers when valid and ready are both high. Ready is combinational from grant/state and the PIPE never back-pressures. Inputs must hold stable while valid is high and ready is low.
- FSM states: IDLE, RPL, TLP.
  - IDLE: arbitration happens every cycle.
  - RPL and TLP: the FSM stays in the state, granting only that stream, until a beat with last=1 is accepted, then returns to IDLE.
  - A single-beat packet (valid with last in IDLE) is accepted and the FSM stays in IDLE.
- Priority in IDLE:
  - Replay first.
  - Then DLLP.
  - Then new TLP.
  - At most one requester gets ready per cycle.
- DLCMSM gating:
  - Replay and new-TLP grants only when `dlcmsm_i`=ACTIVE.
  - DLLPs are granted in INIT and ACTIVE.
  - In INACTIVE nothing is granted.
  - A state change mid-TLP does not abort the packet. It completes, and gating applies at the next IDLE.
- Simultaneous events:
  - A replay request arriving during a new-TLP stream waits for that TLP's last beat. It is then granted ahead of a pending DLLP.
  - A DLLP pending during any TLP stream waits and is never interleaved.
- Reset:
  - Outputs: `pipe_txvalid_o`=0, `pipe_txdata_o`=0, all ready=0, `busy_o`=0.
  - State: FSM=IDLE, fairness counter=0.
  - A TLP in flight at reset is dropped; upstream restarts it.

## Timing
- Grant latency 0: ready is asserted in the same cycle as valid when granted in IDLE.
- Datapath latency 1: an accepted beat appears on `pipe_txdata_o` with `pipe_txvalid_o`=1 on the next `sclk` edge.
- Cycles with no accepted beat drive `pipe_txvalid_o`=0, and `pipe_txdata_o` holds its last value.
- No bubble between packets: last beat accepted in cycle N means the next grant is possible in cycle N+1, with output in N+2.
- Back-to-back DLLPs are accepted every cycle.

## Configuration
- `DLL_TX_ARB_FAIR_EN` defined:
  - The fairness counter counts consecutive DLLP grants while `tlp_valid_i`=1 and no replay is pending.
  - At `DLLP_BURST_MAX` the next IDLE arbitration grants the new TLP over the DLLP. Replay still wins.
  - The counter clears on any TLP grant or when `tlp_valid_i`=0. It saturates and never wraps.
- Not defined: strict priority, the counter is absent, and new TLPs can be starved by continuous DLLPs.

## Structure
- Shared package `dll_pkg`:
  - DLCMSM encoding enum (`DL_INACTIVE`, `DL_INIT`, `DL_ACTIVE`).
  - TX arbiter state enum (`ARB_IDLE`, `ARB_RPL`, `ARB_TLP`).
  - Requester index constants.
- Sub-module `dll_tx_arb_prio` holds the combinational priority and gating selector (IDLE grant vector). The FSM, fairness counter and output register stay in the top module.

## Test plan
- Reset mid-TLP: assert `srst_n`=0 during beat 2 of a 4-beat new TLP. Required: all outputs 0 immediately, and after release IDLE grants a replay of the same TLP with no residue.
- Priority: in ACTIVE, raise replay, DLLP and new TLP together in one cycle. Required: replay granted, its 3 beats on PIPE in cycles +1..+3, then the DLLP, then the new TLP, with no gaps.
- Atomicity: DLLP valid raised during beat 1 of a 4-beat new TLP. Required: `dllp_ready_o`=0 for 3 cycles and the DLLP is accepted the cycle after the last beat.
- Gating: `dlcmsm_i`=INIT with all three valid. Required: only DLLPs granted; switch to ACTIVE and the replay is granted in the same cycle.
- Fairness (macro on, DLLP_BURST_MAX=8): continuous DLLPs plus a waiting new TLP. Required: 8 DLLPs, then the TLP's full packet, then DLLPs resume. With macro off, the TLP is never granted.
- Idle output: no valids for 10 cycles. Required: `pipe_txvalid_o`=0 throughout and `pipe_txdata_o` unchanged.
